// File: rtl/spike_isi_encoder.sv
// Spike edge detector with inter-spike-interval measurement, show-ahead ISI FIFO
// and a windowed spike-rate tally for readout.
module spike_isi_encoder #(
    parameter int unsigned ISI_W      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RATE_W     = 8,
    parameter int unsigned WIN_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              spike,
    output logic [ISI_W-1:0]  isi_data,
    output logic              isi_valid,
    input  logic              isi_ready,
    output logic              overflow,
    output logic [RATE_W-1:0] rate_count,
    output logic              rate_valid
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned WinW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WinW-1:0] WinLast  = WinW'(WIN_CYCLES - 1);
    localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

    logic                spike_q;
    logic                armed_q, armed_d;
    logic [ISI_W-1:0]    isi_cnt_q, isi_cnt_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                overflow_q, overflow_d;
    logic [WinW-1:0]     win_cnt_q, win_cnt_d;
    logic [RATE_W-1:0]   tally_q, tally_d;
    logic [RATE_W-1:0]   rate_count_q, rate_count_d;
    logic                rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0]    mem_q [FIFO_DEPTH];

    logic spike_edge;
    logic push;
    logic pop;
    logic full;
    logic wr_en;

    assign spike_edge = enable & spike & ~spike_q;
    assign push       = spike_edge & armed_q;
    assign isi_valid  = (cnt_q != '0);
    assign pop        = isi_valid & isi_ready;
    assign full       = (cnt_q == FifoFull);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign wr_en      = push & (~full | pop);

    assign isi_data   = isi_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow   = overflow_q;
    assign rate_count = rate_count_q;
    assign rate_valid = rate_valid_q;

    always_comb begin
        armed_d      = armed_q | spike_edge;
        isi_cnt_d    = isi_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        overflow_d   = overflow_q | (push & full & ~pop);
        win_cnt_d    = win_cnt_q;
        tally_d      = tally_q;
        rate_count_d = rate_count_q;
        rate_valid_d = 1'b0;

        if (spike_edge) begin
            isi_cnt_d = ISI_W'(1);
        end else if (enable && !(&isi_cnt_q)) begin
            isi_cnt_d = isi_cnt_q + ISI_W'(1);
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (enable) begin
            if (win_cnt_q == WinLast) begin
                // An edge in the closing cycle belongs to the closing window.
                win_cnt_d    = '0;
                tally_d      = '0;
                rate_count_d = (&tally_q) ? tally_q : tally_q + RATE_W'(spike_edge);
                rate_valid_d = 1'b1;
            end else begin
                win_cnt_d = win_cnt_q + WinW'(1);
                if (spike_edge && !(&tally_q)) tally_d = tally_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spike_q      <= 1'b1;
            armed_q      <= 1'b0;
            isi_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            win_cnt_q    <= '0;
            tally_q      <= '0;
            rate_count_q <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            spike_q      <= spike;
            armed_q      <= armed_d;
            isi_cnt_q    <= isi_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            win_cnt_q    <= win_cnt_d;
            tally_q      <= tally_d;
            rate_count_q <= rate_count_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) mem_q[wr_ptr_q] <= isi_cnt_q;
    end

endmodule

// File: tb/tb_spike_isi_encoder.sv
// Directed bench for spike_isi_encoder: ISI measurement, FIFO full/overflow,
// saturation, rate windows and reset behaviour.
module tb_spike_isi_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        spike = 1'b0;
    logic [11:0] isi_data;
    logic        isi_valid;
    logic        isi_ready = 1'b0;
    logic        overflow;
    logic [7:0]  rate_count;
    logic        rate_valid;

    int n_cmp = 0;
    int n_fail = 0;

    spike_isi_encoder #(
        .ISI_W(12), .FIFO_DEPTH(4), .RATE_W(8), .WIN_CYCLES(1000)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .spike(spike),
        .isi_data(isi_data), .isi_valid(isi_valid), .isi_ready(isi_ready),
        .overflow(overflow), .rate_count(rate_count), .rate_valid(rate_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in cycle 0: the next rising edge is the first out of reset.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        spike = 1'b1;
        isi_ready = 1'b0;
        do_reset();
        n_cmp++;
        if ({isi_valid, isi_data, overflow, rate_valid, rate_count} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b d=%0d ovf=%0b rv=%0b rc=%0d want all 0",
                     isi_valid, isi_data, overflow, rate_valid, rate_count);
        end
    endtask

    task automatic test_isi_basic();
        spike = 1'b0;
        isi_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            spike = (c == 10 || c == 11 || c == 25 || c == 26 || c == 65 || c == 66);
            if (c == 11 || c == 25 || c == 27) begin
                n_cmp++;
                if (isi_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_no_valid c=%0d: got %0b want 0", c, isi_valid);
                end
            end
            if (c == 26 || c == 66) begin
                n_cmp++;
                if ({isi_valid, isi_data} !== {1'b1, (c == 26) ? 12'd15 : 12'd40}) begin
                    n_fail++;
                    $display("FAIL basic_sample c=%0d: got v=%0b d=%0d want v=1 d=%0d",
                             c, isi_valid, isi_data, (c == 26) ? 15 : 40);
                end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int popped;
        spike = 1'b0;
        isi_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            spike = (c % 5 == 0) && (c >= 5) && (c <= 30);
            if (c == 30) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_early: got %0b want 0", overflow);
                end
            end
            tick();
        end
        n_cmp++;
        if ({overflow, isi_valid, isi_data} !== {1'b1, 1'b1, 12'd5}) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%0b v=%0b d=%0d want ovf=1 v=1 d=5",
                     overflow, isi_valid, isi_data);
        end
        isi_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 10; c++) begin
            if (isi_valid) begin
                popped++;
                n_cmp++;
                if (isi_data !== 12'd5) begin
                    n_fail++;
                    $display("FAIL ovf_drain_data: got %0d want 5", isi_data);
                end
            end
            tick();
        end
        n_cmp++;
        if (popped != 4) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d want 4", popped);
        end
        n_cmp++;
        if ({overflow, isi_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%0b v=%0b want ovf=1 v=0", overflow, isi_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [11:0] exp_q [4];
        exp_q = '{12'd3, 12'd4, 12'd5, 12'd8};
        spike = 1'b0;
        isi_ready = 1'b0;
        do_reset();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_ovf_cleared: got %0b want 0", overflow);
        end
        for (int c = 0; c < 29; c++) begin
            spike = (c == 5 || c == 7 || c == 10 || c == 14 || c == 19 || c == 27);
            isi_ready = (c == 27);
            if (c == 26 || c == 27) begin
                n_cmp++;
                if ({isi_valid, isi_data} !== {1'b1, 12'd2}) begin
                    n_fail++;
                    $display("FAIL fpp_head_stable c=%0d: got v=%0b d=%0d want v=1 d=2",
                             c, isi_valid, isi_data);
                end
            end
            tick();
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_no_ovf: got %0b want 0", overflow);
        end
        isi_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({isi_valid, isi_data} !== {1'b1, exp_q[i]}) begin
                n_fail++;
                $display("FAIL fpp_order[%0d]: got v=%0b d=%0d want v=1 d=%0d",
                         i, isi_valid, isi_data, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if (isi_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_empty: got %0b want 0", isi_valid);
        end
    endtask

    task automatic test_saturation();
        spike = 1'b0;
        isi_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5008; c++) begin
            spike = (c == 5 || c == 5006);
            if (c == 5006) begin
                n_cmp++;
                if (isi_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_premature: got %0b want 0", isi_valid);
                end
            end
            if (c == 5007) begin
                n_cmp++;
                if ({isi_valid, isi_data} !== {1'b1, 12'd4095}) begin
                    n_fail++;
                    $display("FAIL sat_value: got v=%0b d=%0d want v=1 d=4095",
                             isi_valid, isi_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_rate_window();
        int pulses;
        spike = 1'b0;
        isi_ready = 1'b1;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 2002; c++) begin
            spike = (c == 100 || c == 200 || c == 300 || c == 400 || c == 500 ||
                     c == 600 || c == 999);
            if (rate_valid) pulses++;
            if (c == 999) begin
                n_cmp++;
                if ({rate_valid, rate_count} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL rate_before_close: got rv=%0b rc=%0d want rv=0 rc=0",
                             rate_valid, rate_count);
                end
            end
            if (c == 1000 || c == 2000) begin
                n_cmp++;
                if ({rate_valid, rate_count} !== {1'b1, (c == 1000) ? 8'd7 : 8'd0}) begin
                    n_fail++;
                    $display("FAIL rate_close c=%0d: got rv=%0b rc=%0d want rv=1 rc=%0d",
                             c, rate_valid, rate_count, (c == 1000) ? 7 : 0);
                end
            end
            tick();
        end
        n_cmp++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL rate_pulse_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        spike = 1'b1;
        isi_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 1043; c++) begin
            spike = (c < 5) || c == 10 || c == 20 || c == 30 || c == 51 || c == 61;
            reset = (c == 40);
            if (c == 11 || c == 52) begin
                n_cmp++;
                if (isi_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rearm_no_sample c=%0d: got %0b want 0", c, isi_valid);
                end
            end
            if (c == 21 || c == 31 || c == 62) begin
                n_cmp++;
                if ({isi_valid, isi_data} !== {1'b1, 12'd10}) begin
                    n_fail++;
                    $display("FAIL rearm_sample c=%0d: got v=%0b d=%0d want v=1 d=10",
                             c, isi_valid, isi_data);
                end
            end
            if (c == 41) begin
                n_cmp++;
                if ({isi_valid, overflow, rate_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL midreset_clear: got v=%0b ovf=%0b rv=%0b want 0 0 0",
                             isi_valid, overflow, rate_valid);
                end
            end
            if (c == 1041) begin
                n_cmp++;
                if ({rate_valid, rate_count} !== {1'b1, 8'd2}) begin
                    n_fail++;
                    $display("FAIL midreset_tally: got rv=%0b rc=%0d want rv=1 rc=2",
                             rate_valid, rate_count);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_isi_basic();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_rate_window();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
